// File: rtl/systolic_pkg.sv
//------------------------------------------------------------------------------
// Module   : systolic_pkg
// Brief    : Shared FSM encoding and default operand width for the systolic array.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package systolic_pkg;

    localparam int c_DEFAULT_DATA_WIDTH = 32;

    localparam int         c_ST_W      = 2;
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_STREAM = 2'd1;
    localparam logic [1:0] c_ST_DRAIN  = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/skew_delay.sv
//------------------------------------------------------------------------------
// Module   : skew_delay
// Brief    : One lane's delay line: DEPTH skew registers plus a final output
//            register, carrying operand and load strobe side by side.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module skew_delay #(
    parameter int DEPTH      = 0,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_load,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_load
);

    logic [DATA_WIDTH-1:0] r_data [0:DEPTH];
    logic [DEPTH:0]        r_load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k <= DEPTH; k++) begin
                r_data[k] <= '0;
            end
            r_load <= '0;
        end else begin
            r_data[0] <= i_data;
            r_load[0] <= i_load;
            for (int k = 1; k <= DEPTH; k++) begin
                r_data[k] <= r_data[k-1];
                r_load[k] <= r_load[k-1];
            end
        end
    end

    assign o_data = r_data[DEPTH];
    assign o_load = r_load[DEPTH];

endmodule

`default_nettype wire

// File: rtl/skew_feeder.sv
//------------------------------------------------------------------------------
// Module   : skew_feeder
// Brief    : Diagonally skews operand beats onto a systolic array edge and
//            sequences stream / drain / done.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module skew_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int LANES      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic                        in_last,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic [LANES-1:0]            out_load,
    output logic                        busy,
    output logic                        done
);

    localparam int                 c_CNT_W      = $clog2(LANES);
    localparam logic [c_CNT_W-1:0] c_DRAIN_LAST = c_CNT_W'(LANES - 2);

    logic [c_ST_W-1:0]  r_state;
    logic [c_ST_W-1:0]  w_state_nxt;
    logic [c_CNT_W-1:0] r_drain_cnt;
    logic               r_done;
    logic               w_accept;

    assign in_ready = (r_state == c_ST_IDLE) || (r_state == c_ST_STREAM);
    assign busy     = (r_state == c_ST_STREAM) || (r_state == c_ST_DRAIN);
    assign done     = r_done;
    assign w_accept = in_valid && in_ready;

    // Idle cycles feed a zero, load-low bubble so every lane keeps its skew.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] w_lane_in;

            assign w_lane_in = w_accept ? in_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;

            skew_delay #(
                .DEPTH      (gi),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_delay (
                .clk    (clk),
                .rst    (rst),
                .i_data (w_lane_in),
                .i_load (w_accept),
                .o_data (out_data[gi*DATA_WIDTH +: DATA_WIDTH]),
                .o_load (out_load[gi])
            );
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = in_last ? c_ST_DRAIN : c_ST_STREAM;
                end
            end
            c_ST_STREAM: begin
                if (w_accept && in_last) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (r_drain_cnt == c_DRAIN_LAST) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // done trails DONE by one register so it lands after the final lane output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_ST_IDLE;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_done      <= (r_state == c_ST_DONE);
            r_drain_cnt <= (r_state == c_ST_DRAIN) ? r_drain_cnt + 1'b1 : '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_skew_feeder.sv
//------------------------------------------------------------------------------
// Module   : tb_skew_feeder
// Brief    : Directed self-checking bench for skew_feeder (LANES=4 and LANES=2).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_skew_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic         a_valid, a_ready, a_last, a_busy, a_done;
    logic [127:0] a_data, a_odata;
    logic [3:0]   a_load;

    logic         b_valid, b_ready, b_last, b_busy, b_done;
    logic [15:0]  b_data, b_odata;
    logic [1:0]   b_load;

    int n_checks = 0;
    int n_pass   = 0;

    skew_feeder #(.DATA_WIDTH(32), .LANES(4)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .in_valid (a_valid),
        .in_ready (a_ready),
        .in_data  (a_data),
        .in_last  (a_last),
        .out_data (a_odata),
        .out_load (a_load),
        .busy     (a_busy),
        .done     (a_done)
    );

    skew_feeder #(.DATA_WIDTH(8), .LANES(2)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .in_valid (b_valid),
        .in_ready (b_ready),
        .in_data  (b_data),
        .in_last  (b_last),
        .out_data (b_odata),
        .out_load (b_load),
        .busy     (b_busy),
        .done     (b_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] beat(input int l0, input int l1, input int l2, input int l3);
        return {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
    endfunction

    function automatic logic [31:0] lane(input int k);
        return a_odata[k*32 +: 32];
    endfunction

    task automatic drive(input logic v, input logic [127:0] d, input logic l);
        a_valid = v;
        a_data  = d;
        a_last  = l;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int ready_low, done_cnt, done_cyc, busy_cnt, stale, early;

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, 1'b0);
        b_valid = 1'b0; b_data = '0; b_last = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_load",  64'(a_load),  64'h0);
        check("rst_data",  64'(a_odata), 64'h0);
        check("rst_busy",  64'(a_busy),  64'h0);
        check("rst_done",  64'(a_done),  64'h0);
        step();
        rst = 1'b1;
        check("rst_ready_after_release", 64'(a_ready), 64'h1);

        // Three back-to-back beats, last on the third.
        drive(1'b1, beat(1, 2, 3, 4), 1'b0); step();
        check("s1_l0_t1", 64'(lane(0)), 64'd1);
        check("s1_ld0_t1", 64'(a_load[0]), 64'h1);
        drive(1'b1, beat(5, 6, 7, 8), 1'b0); step();
        check("s1_l0_t2", 64'(lane(0)), 64'd5);
        check("s1_l1_t2", 64'(lane(1)), 64'd2);
        drive(1'b1, beat(9, 10, 11, 12), 1'b1); step();
        check("s1_l0_t3", 64'(lane(0)), 64'd9);
        check("s1_ready_t3", 64'(a_ready), 64'h0);
        check("s1_busy_t3", 64'(a_busy), 64'h1);
        drive(1'b0, '0, 1'b0); step();
        check("s1_l3_t4", 64'(lane(3)), 64'd4);
        check("s1_load_t4", 64'(a_load), 64'hE);
        step();
        check("s1_l3_t5", 64'(lane(3)), 64'd8);
        step();
        check("s1_l3_t6", 64'(lane(3)), 64'd12);
        check("s1_done_t6", 64'(a_done), 64'h0);
        check("s1_busy_t6", 64'(a_busy), 64'h0);
        step();
        check("s1_done_t7", 64'(a_done), 64'h1);
        check("s1_load_t7", 64'(a_load), 64'h0);
        step();
        check("s1_done_t8", 64'(a_done), 64'h0);
        check("s1_ready_t8", 64'(a_ready), 64'h1);
        step();

        // Same stream with an in_valid gap in the second cycle.
        drive(1'b1, beat(1, 2, 3, 4), 1'b0); step();
        check("s2_l0_t1", 64'(lane(0)), 64'd1);
        drive(1'b0, '0, 1'b0); step();
        check("s2_ld0_t2", 64'(a_load[0]), 64'h0);
        check("s2_l0_t2", 64'(lane(0)), 64'd0);
        drive(1'b1, beat(5, 6, 7, 8), 1'b0); step();
        check("s2_l0_t3", 64'(lane(0)), 64'd5);
        check("s2_ld1_t3", 64'(a_load[1]), 64'h0);
        drive(1'b1, beat(9, 10, 11, 12), 1'b1); step();
        check("s2_l0_t4", 64'(lane(0)), 64'd9);
        check("s2_l1_t4", 64'(lane(1)), 64'd6);
        check("s2_l3_t4", 64'(lane(3)), 64'd4);
        drive(1'b0, '0, 1'b0); step();
        check("s2_ld3_t5", 64'(a_load[3]), 64'h0);
        check("s2_l3_t5", 64'(lane(3)), 64'd0);
        step();
        check("s2_l3_t6", 64'(lane(3)), 64'd8);
        step();
        check("s2_l3_t7", 64'(lane(3)), 64'd12);
        step();
        check("s2_done_t8", 64'(a_done), 64'h1);
        repeat (2) step();

        // Single beat flagged last.
        ready_low = 0; done_cnt = 0; done_cyc = 0; busy_cnt = 0;
        drive(1'b1, beat(21, 22, 23, 24), 1'b1); step();
        drive(1'b0, '0, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            if (!a_ready) ready_low++;
            if (a_busy) busy_cnt++;
            if (a_done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (c == 4) check("s3_l3_t4", 64'(lane(3)), 64'd24);
            step();
        end
        check("s3_ready_low_cycles", 64'(ready_low), 64'd4);
        check("s3_drain_cycles", 64'(busy_cnt), 64'd3);
        check("s3_done_pulses", 64'(done_cnt), 64'd1);
        check("s3_done_cycle", 64'(done_cyc), 64'd5);

        // Reset asserted in the middle of DRAIN.
        drive(1'b1, beat(1, 2, 3, 4), 1'b0); step();
        drive(1'b1, beat(5, 6, 7, 8), 1'b0); step();
        drive(1'b1, beat(9, 10, 11, 12), 1'b1); step();
        drive(1'b0, '0, 1'b0); step();
        check("s4_busy_pre", 64'(a_busy), 64'h1);
        rst = 1'b0;
        #1;
        check("s4_load_async", 64'(a_load), 64'h0);
        check("s4_data_async", 64'(a_odata), 64'h0);
        check("s4_busy_async", 64'(a_busy), 64'h0);
        step();
        rst = 1'b1;
        check("s4_ready_release", 64'(a_ready), 64'h1);
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (a_load != 4'h0) stale++;
        end
        check("s4_no_stale", 64'(stale), 64'd0);
        drive(1'b1, beat(31, 32, 33, 34), 1'b1); step();
        drive(1'b0, '0, 1'b0);
        check("s4_new_l0", 64'(lane(0)), 64'd31);
        check("s4_new_ld0", 64'(a_load[0]), 64'h1);
        repeat (8) step();

        // in_valid held high through DRAIN.
        drive(1'b1, beat(41, 42, 43, 44), 1'b1); step();
        check("s5_l0_t1", 64'(lane(0)), 64'd41);
        drive(1'b1, beat(51, 52, 53, 54), 1'b1);
        early = 0;
        for (int c = 1; c <= 4; c++) begin
            if (a_ready) early++;
            if (c >= 2 && a_load[0]) early++;
            step();
        end
        check("s5_no_accept_in_drain", 64'(early), 64'd0);
        check("s5_ready_t5", 64'(a_ready), 64'h1);
        check("s5_ld0_t5", 64'(a_load[0]), 64'h0);
        step();
        drive(1'b0, '0, 1'b0);
        check("s5_l0_t6", 64'(lane(0)), 64'd51);
        repeat (4) step();
        check("s5_done_t10", 64'(a_done), 64'h1);
        step();

        // Two-lane, 8-bit instance.
        b_valid = 1'b1; b_data = 16'hFFFF; b_last = 1'b1; step();
        b_valid = 1'b0; b_data = '0; b_last = 1'b0;
        check("s6_load_t1", 64'(b_load), 64'h1);
        check("s6_data_t1", 64'(b_odata), 64'h00FF);
        check("s6_ready_t1", 64'(b_ready), 64'h0);
        step();
        check("s6_load_t2", 64'(b_load), 64'h2);
        check("s6_data_t2", 64'(b_odata), 64'hFF00);
        check("s6_done_t2", 64'(b_done), 64'h0);
        step();
        check("s6_done_t3", 64'(b_done), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
